// File: rtl/seq_adder.sv
// Multi-cycle adder: adds one CHUNK-bit slice per clock, LSB slice first, and
// publishes sum/cout/ovf together with a one-cycle done pulse. WIDTH must be a multiple of CHUNK.
module seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);

  typedef enum logic {S_IDLE, S_ADD} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic [CHUNK:0]   w_slice;
  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] w_b_next;
  logic             w_last;
  logic             w_ovf;

  assign w_slice = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
  assign w_last  = (r_cnt == CW'(NCHUNK - 1));
  // On the last slice the low bits of r_a/r_b hold the original operand MSBs.
  assign w_ovf   = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_slice[CHUNK-1] ^ w_slice[CHUNK];

  // r_a rotates right, refilling from the top with finished slices, so after
  // NCHUNK steps it holds the complete sum.
  generate
    if (NCHUNK == 1) begin : g_single
      assign w_a_next = w_slice[CHUNK-1:0];
      assign w_b_next = '0;
    end else begin : g_multi
      assign w_a_next = {w_slice[CHUNK-1:0], r_a[WIDTH-1:CHUNK]};
      assign w_b_next = {{CHUNK{1'b0}}, r_b[WIDTH-1:CHUNK]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_a     <= w_a_next;
          r_b     <= w_b_next;
          r_carry <= w_slice[CHUNK];
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            sum     <= w_a_next;
            cout    <= w_slice[CHUNK];
            ovf     <= w_ovf;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_adder.sv
// Bench for seq_adder: four instances, (16,4) (16,16) (32,1) (1,1), checked against an
// arithmetic model of A+B+cin with signed overflow judged from operand and result signs.
module tb_seq_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  st;
  logic [3:0]  ic;
  logic [31:0] ia [4];
  logic [31:0] ib [4];
  logic [3:0]  o_busy, o_done, o_cout, o_ovf;
  logic [15:0] sum0, sum1;
  logic [31:0] sum2;
  logic [0:0]  sum3;

  int total = 0;
  int bad   = 0;
  int nck [4] = '{4, 1, 32, 1};
  int wd  [4] = '{16, 16, 32, 1};

  seq_adder #(.WIDTH(16), .CHUNK(4)) u_m (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .a(ia[0][15:0]), .b(ib[0][15:0]), .cin(ic[0]),
    .busy(o_busy[0]), .done(o_done[0]), .sum(sum0), .cout(o_cout[0]), .ovf(o_ovf[0]));
  seq_adder #(.WIDTH(16), .CHUNK(16)) u_f (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .a(ia[1][15:0]), .b(ib[1][15:0]), .cin(ic[1]),
    .busy(o_busy[1]), .done(o_done[1]), .sum(sum1), .cout(o_cout[1]), .ovf(o_ovf[1]));
  seq_adder #(.WIDTH(32), .CHUNK(1)) u_s (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .a(ia[2]), .b(ib[2]), .cin(ic[2]),
    .busy(o_busy[2]), .done(o_done[2]), .sum(sum2), .cout(o_cout[2]), .ovf(o_ovf[2]));
  seq_adder #(.WIDTH(1), .CHUNK(1)) u_w (
    .clk(clk), .rst_n(rst_n), .start(st[3]), .a(ia[3][0:0]), .b(ib[3][0:0]), .cin(ic[3]),
    .busy(o_busy[3]), .done(o_done[3]), .sum(sum3), .cout(o_cout[3]), .ovf(o_ovf[3]));

  function automatic logic [31:0] get_sum(input int sel);
    case (sel)
      0:       return {16'd0, sum0};
      1:       return {16'd0, sum1};
      2:       return sum2;
      default: return {31'd0, sum3};
    endcase
  endfunction

  // Reference: {ovf, cout, sum} of x+y+c truncated to w bits.
  function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic c);
    logic [63:0] m, xm, ym, t, s;
    logic co, ov;
    m  = (64'd1 << w) - 64'd1;
    xm = {32'd0, x} & m;
    ym = {32'd0, y} & m;
    t  = xm + ym + {63'd0, c};
    s  = t & m;
    co = t[w];
    ov = (xm[w-1] == ym[w-1]) && (s[w-1] != xm[w-1]);
    return {ov, co, s[31:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start one operation, scramble inputs after the start edge, wait for done,
  // and check latency, result stability and final values. Returns in the done cycle.
  task automatic do_op(input int sel, input logic [31:0] x, input logic [31:0] y, input logic c);
    logic [33:0] e;
    logic [31:0] hold;
    int n;
    e    = model(wd[sel], x, y, c);
    hold = get_sum(sel);
    ia[sel] = x; ib[sel] = y; ic[sel] = c; st[sel] = 1'b1;
    tick;
    st[sel] = 1'b0;
    ia[sel] = $urandom; ib[sel] = $urandom; ic[sel] = 1'($urandom);
    total++;
    if (o_busy[sel] !== 1'b1) begin
      bad++; $display("FAIL busy_after_start sel=%0d got=%b want=1", sel, o_busy[sel]);
    end
    n = 0;
    while (o_done[sel] !== 1'b1 && n < 40) begin
      total++;
      if (get_sum(sel) !== hold) begin
        bad++; $display("FAIL sum_hold sel=%0d got=%h want=%h", sel, get_sum(sel), hold);
      end
      tick;
      n++;
    end
    total++;
    if (n != nck[sel]) begin
      bad++; $display("FAIL latency sel=%0d got=%0d want=%0d", sel, n, nck[sel]);
    end
    total++;
    if (get_sum(sel) !== e[31:0]) begin
      bad++; $display("FAIL sum sel=%0d a=%h b=%h cin=%b got=%h want=%h", sel, x, y, c, get_sum(sel), e[31:0]);
    end
    total++;
    if (o_cout[sel] !== e[32]) begin
      bad++; $display("FAIL cout sel=%0d a=%h b=%h cin=%b got=%b want=%b", sel, x, y, c, o_cout[sel], e[32]);
    end
    total++;
    if (o_ovf[sel] !== e[33]) begin
      bad++; $display("FAIL ovf sel=%0d a=%h b=%h cin=%b got=%b want=%b", sel, x, y, c, o_ovf[sel], e[33]);
    end
    total++;
    if (o_busy[sel] !== 1'b0) begin
      bad++; $display("FAIL busy_at_done sel=%0d got=%b want=0", sel, o_busy[sel]);
    end
    $display("op sel=%0d a=%h b=%h cin=%b -> sum=%h cout=%b ovf=%b lat=%0d",
             sel, x, y, c, get_sum(sel), o_cout[sel], o_ovf[sel], n);
  endtask

  task automatic check_idle_zero(input string tag);
    total++;
    if ({o_busy[0], o_done[0], o_cout[0], o_ovf[0]} !== 4'b0000 || sum0 !== 16'h0000) begin
      bad++;
      $display("FAIL %s got busy=%b done=%b sum=%h cout=%b ovf=%b want all 0",
               tag, o_busy[0], o_done[0], sum0, o_cout[0], o_ovf[0]);
    end
  endtask

  task automatic test_reset;
    check_idle_zero("reset_state");
    total++;
    if (o_busy !== 4'b0000 || o_done !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got busy=%b done=%b want 0000", o_busy, o_done);
    end
  endtask

  task automatic test_basic;
    do_op(0, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
    tick;
    total++;
    if (o_done[0] !== 1'b0) begin
      bad++; $display("FAIL done_pulse_width got=%b want=0", o_done[0]);
    end
  endtask

  task automatic test_back_to_back;
    do_op(0, 32'h0000_7FFF, 32'h0000_0001, 1'b0);
    do_op(0, 32'h0000_1234, 32'h0000_4321, 1'b1);
  endtask

  task automatic test_hold;
    logic [31:0] hold;
    tick;
    hold = get_sum(0);
    for (int i = 0; i < 4; i++) begin
      ia[0] = $urandom; ib[0] = $urandom; ic[0] = 1'($urandom);
      tick;
      total++;
      if (get_sum(0) !== hold || o_done[0] !== 1'b0) begin
        bad++; $display("FAIL idle_hold got sum=%h done=%b want sum=%h done=0", get_sum(0), o_done[0], hold);
      end
    end
  endtask

  // start held high every cycle: an operation is accepted every 5th edge only.
  task automatic test_start_while_busy;
    logic [31:0] pa [25];
    logic [31:0] pb [25];
    logic        pc [25];
    logic [33:0] e;
    for (int i = 0; i < 25; i++) begin
      pa[i] = $urandom; pb[i] = $urandom; pc[i] = 1'($urandom);
      ia[0] = pa[i]; ib[0] = pb[i]; ic[0] = pc[i]; st[0] = 1'b1;
      tick;
      total++;
      if (o_done[0] !== (i % 5 == 4)) begin
        bad++; $display("FAIL busy_start_done edge=%0d got=%b want=%b", i, o_done[0], (i % 5 == 4));
      end
      total++;
      if (o_busy[0] !== (i % 5 != 4)) begin
        bad++; $display("FAIL busy_start_busy edge=%0d got=%b want=%b", i, o_busy[0], (i % 5 != 4));
      end
      if (i % 5 == 4) begin
        e = model(16, pa[i-4], pb[i-4], pc[i-4]);
        total++;
        if ({o_ovf[0], o_cout[0], get_sum(0)} !== e) begin
          bad++; $display("FAIL busy_start_result edge=%0d got=%h want=%h", i,
                          {o_ovf[0], o_cout[0], get_sum(0)}, e);
        end
        $display("op sel=0 a=%h b=%h cin=%b -> sum=%h (start held)", pa[i-4][15:0], pb[i-4][15:0],
                 pc[i-4], get_sum(0));
      end
    end
    st[0] = 1'b0;
    tick;
    total++;
    if (o_done[0] !== 1'b0 || o_busy[0] !== 1'b0) begin
      bad++; $display("FAIL busy_start_tail got done=%b busy=%b want 0 0", o_done[0], o_busy[0]);
    end
  endtask

  task automatic test_reset_abort;
    do_op(0, 32'h0000_0101, 32'h0000_0202, 1'b0);
    tick;
    ia[0] = 32'h0000_F00F; ib[0] = 32'h0000_0FF0; ic[0] = 1'b1; st[0] = 1'b1;
    tick;
    st[0] = 1'b0;
    tick;
    tick;
    #2 rst_n = 1'b0;
    #1 check_idle_zero("reset_abort_immediate");
    tick;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick;
      total++;
      if (o_done[0] !== 1'b0 || o_busy[0] !== 1'b0) begin
        bad++; $display("FAIL reset_abort_quiet cyc=%0d got done=%b busy=%b want 0 0", i, o_done[0], o_busy[0]);
      end
    end
    do_op(0, 32'h0000_ABCD, 32'h0000_1111, 1'b1);
    tick;
  endtask

  task automatic test_full_adder;
    for (int i = 0; i < 8; i++) begin
      do_op(3, 32'((i >> 2) & 1), 32'((i >> 1) & 1), 1'(i & 1));
      tick;
    end
  endtask

  task automatic test_random;
    int sels [3] = '{0, 1, 2};
    int gap;
    foreach (sels[k]) begin
      for (int n = 0; n < 1000; n++) begin
        do_op(sels[k], $urandom, $urandom, 1'($urandom));
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) tick;
      end
      tick;
    end
  endtask

  initial begin
    rst_n = 1'b1;
    st    = 4'b0000;
    ic    = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      ia[i] = '0;
      ib[i] = '0;
    end
    #2 rst_n = 1'b0;
    #2 test_reset;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    test_basic;
    test_back_to_back;
    test_hold;
    test_start_while_busy;
    test_reset_abort;
    test_full_adder;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_adder.md
SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 SHALL provide parameter CHUNK, default 4: bits added per clock cycle.
REQ-003 SHALL require WIDTH >= 1, CHUNK >= 1 and WIDTH divisible by CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  request a new addition.
REQ-007 SHALL have port a  input  WIDTH  operand A, unsigned or two's complement.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry-in.
REQ-010 SHALL have port busy  output  1  addition in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse: result registers just updated.
REQ-012 SHALL have port sum  output  WIDTH  registered result A+B+cin, modulo 2^WIDTH.
REQ-013 SHALL have port cout  output  1  carry out of bit WIDTH-1.
REQ-014 SHALL have port ovf  output  1  signed overflow: carry into MSB XOR cout.

Function
REQ-015 SHALL implement two states: IDLE and ADD.
REQ-016 In IDLE with start=1, SHALL capture a, b and cin at the rising edge (E0), clear the chunk counter, enter ADD, and drive busy=1.
REQ-017 In ADD, SHALL add one CHUNK-bit slice per cycle, LSB slice first, ripple-carrying the registered carry between slices.
REQ-018 SHALL process slice k at edge E(k+1), for k = 0..NCHUNK-1.
REQ-019 At edge E(NCHUNK), SHALL load sum, cout and ovf, set done=1 for exactly one cycle, set busy=0, and return to IDLE.
REQ-020 Latency from the start-sampling edge to done high SHALL be exactly NCHUNK cycles.
REQ-021 sum, cout and ovf SHALL change only at completion edges and SHALL hold between completions; partial results are never visible.
REQ-022 SHALL ignore start while busy=1; captured operands are unaffected.
REQ-023 SHALL accept start in the cycle done=1 (back-to-back), giving one operation per NCHUNK+1 cycles.
REQ-024 SHALL ignore changes on a, b and cin after E0 until the next accepted start.
REQ-025 With CHUNK = WIDTH (NCHUNK=1), SHALL complete in one cycle; done follows the start edge by one cycle.
REQ-026 With WIDTH=1, CHUNK=1, results SHALL equal the full-adder truth table: sum=a^b^cin, cout=majority(a,b,cin), ovf=cin^cout.
REQ-027 The chunk counter SHALL be sized ceil(log2(NCHUNK+1)) bits and SHALL NOT wrap during an operation.

Reset
REQ-028 rst_n=0 SHALL immediately, without a clock edge, force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0 and counter=0.
REQ-029 Reset during ADD SHALL abort the operation with no done pulse; the first start after rst_n rises begins a fresh operation.
REQ-030 Reset deassertion SHALL be synchronised to clk by the integrator; the block samples start from the first clk edge with rst_n=1.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-031 a=16'hFFFF, b=16'h0001, cin=0, start pulse -> done 4 cycles later; sum=16'h0000, cout=1, ovf=0.
REQ-032 a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1; then a=16'h1234, b=16'h4321, cin=1 started in the done cycle -> sum=16'h5556, cout=0, ovf=0, done 4 cycles later.
REQ-033 Start asserted every cycle during ADD with different operands -> only the first is computed; exactly one done per 5 cycles.
REQ-034 rst_n pulsed low 2 cycles into ADD -> all outputs 0 immediately; no done; a subsequent start completes correctly.
REQ-035 WIDTH=1, CHUNK=1: all 8 (a,b,cin) combinations -> sum and cout match the full-adder truth table; each done follows its start edge by 1 cycle.
REQ-036 Randomised a, b, cin over 1000 operations for (WIDTH,CHUNK) = (16,4), (16,16), (32,1) -> sum, cout and ovf match a reference model.
